// File: rtl/fmul_e4m3_share_ctrl.sv
// Round-robin sequencing controller sharing one multi-cycle e4m3 multiplier.
// Define FMUL_SHARE_CTRL_TIMEOUT_EN to abort WAIT after MAX_LAT cycles.
module fmul_e4m3_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MAX_LAT = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    output logic                 mul_reset,
    input  logic [7:0]           mul_y,
    input  logic                 mul_valid,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [7:0]           resp_y,
    output logic [ID_W-1:0]      resp_id,
    output logic                 resp_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [7:0]      op_a_q, op_a_d;
    logic [7:0]      op_b_q, op_b_d;
    logic [7:0]      y_q, y_d;
    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;

`ifdef FMUL_SHARE_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(MAX_LAT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        int j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(rr_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(j);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && !reset && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        y_d     = y_q;
`ifdef FMUL_SHARE_CTRL_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    op_a_d  = req_a[8*int'(gnt_idx) +: 8];
                    op_b_d  = req_b[8*int'(gnt_idx) +: 8];
                    id_d    = gnt_idx;
                    rr_d    = gnt_idx;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
`ifdef FMUL_SHARE_CTRL_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_valid) begin
                    y_d     = mul_y;
`ifdef FMUL_SHARE_CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RESP;
                end
`ifdef FMUL_SHARE_CTRL_TIMEOUT_EN
                // cnt_q counts WAIT cycles already spent; this is cycle MAX_LAT.
                else if (cnt_q == CW'(MAX_LAT - 1)) begin
                    y_d     = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            y_q     <= '0;
`ifdef FMUL_SHARE_CTRL_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            y_q     <= y_d;
`ifdef FMUL_SHARE_CTRL_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign mul_a      = op_a_q;
    assign mul_b      = op_b_q;
    assign mul_reset  = reset | (state_q == S_LAUNCH);
    assign resp_valid = (state_q == S_RESP);
    assign resp_y     = y_q;
    assign resp_id    = id_q;
    assign busy       = (state_q != S_IDLE);
`ifdef FMUL_SHARE_CTRL_TIMEOUT_EN
    assign resp_err   = err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fmul_e4m3_share_ctrl.sv
// Self-checking bench for fmul_e4m3_share_ctrl with a stub e4m3 multiplier.
module tb_fmul_e4m3_share_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic [7:0]  mul_a, mul_b, mul_y;
    logic        mul_reset, mul_valid;
    logic        resp_valid, resp_ready;
    logic [7:0]  resp_y;
    logic [1:0]  resp_id;
    logic        resp_err, busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fmul_e4m3_share_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_reset(mul_reset),
        .mul_y(mul_y), .mul_valid(mul_valid),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_y(resp_y), .resp_id(resp_id), .resp_err(resp_err),
        .busy(busy)
    );

    // Simplified e4m3 product: zeros, normals, saturating exponent.
    function automatic logic [7:0] fmul_ref(input logic [7:0] a, input logic [7:0] b);
        logic s;
        int   e, m;
        s = a[7] ^ b[7];
        if (a[6:0] == 7'd0 || b[6:0] == 7'd0) return {s, 7'd0};
        e = int'(a[6:3]) + int'(b[6:3]) - 7;
        m = (8 + int'(a[2:0])) * (8 + int'(b[2:0]));
        if (m >= 128) begin e++; m = m >> 4; end
        else m = m >> 3;
        if (e < 1) e = 1;
        if (e > 15) e = 15;
        return {s, 4'(e), 3'(m)};
    endfunction

    // Stub multiplier: restarts on mul_reset, zero operands finish first.
    logic [7:0] scnt = 8'd0;
    logic       stub_en;
    logic       zero_op;
    always @(posedge clock) begin
        if (mul_reset) scnt <= 8'd0;
        else if (scnt != 8'hff) scnt <= scnt + 8'd1;
    end
    assign zero_op   = (mul_a[6:0] == 7'd0) || (mul_b[6:0] == 7'd0);
    assign mul_valid = stub_en && (scnt >= (zero_op ? 8'd0 : 8'd3));
    assign mul_y     = fmul_ref(mul_a, mul_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: protocol invariants plus a round-robin model of grant order.
    int last_g = 3;
    int grants[$];
    int rids[$];
    int pulses = 0;
    always @(negedge clock) begin
        #2;
        if (reset) begin
            last_g = 3;
        end else begin
            chk("ready_onehot", ($countones(req_ready) > 1) ? 1 : 0, 0);
            chk("ready_while_busy", (busy && req_ready != 4'd0) ? 1 : 0, 0);
            if (req_ready != 4'd0) begin
                int g, e, j;
                g = -1;
                e = -1;
                for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
                for (int k = 1; k <= 4; k++) begin
                    j = (last_g + k) % 4;
                    if (e < 0 && req_valid[j]) e = j;
                end
                chk("rr_grant", g, e);
                last_g = g;
                grants.push_back(g);
            end
            if (resp_valid && resp_ready) rids.push_back(int'(resp_id));
            if (mul_reset) pulses++;
        end
    end

    task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b,
                           output int lat, output logic [7:0] y,
                           output int rid, output logic err);
        int n;
        lat = -1; y = 8'hxx; rid = -1; err = 1'bx;
        @(negedge clock);
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        req_valid[id]    = 1'b1;
        resp_ready       = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin @(negedge clock); #1; n++; end
        @(negedge clock);
        req_valid[id] = 1'b0;
        n = 1;
        #1;
        while (!resp_valid && n < 40) begin @(negedge clock); #1; n++; end
        if (resp_valid) begin
            lat = n; y = resp_y; rid = int'(resp_id); err = resp_err;
        end
        @(negedge clock);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 200) begin @(negedge clock); #1; n++; end
        chk(nm, busy, 0);
    endtask

    typedef struct {
        int         id;
        logic [7:0] a, b, y;
        int         lat;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] y;
    } exp_t;

    vec_t       vecs[6];
    exp_t       sb[$];
    logic [7:0] ra[4], rb[4];
    int         lat, rid;
    logic [7:0] y;
    logic       err;
    int         exp_order[5];
    localparam int NRAND = 60;

    initial begin
        vecs[0] = '{0, 8'h38, 8'h40, 8'h40, 6};
        vecs[1] = '{2, 8'h00, 8'h48, 8'h00, 3};
        vecs[2] = '{1, 8'h40, 8'h40, 8'h48, 6};
        vecs[3] = '{3, 8'h3C, 8'h3C, 8'h41, 6};
        vecs[4] = '{1, 8'hB8, 8'h40, 8'hC0, 6};
        vecs[5] = '{3, 8'h48, 8'h80, 8'h80, 3};
        exp_order = '{0, 1, 2, 3, 0};

        reset = 1'b1; req_valid = 4'b0001; req_a = '0; req_b = '0;
        resp_ready = 1'b0; stub_en = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_y", resp_y, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_mul_reset", mul_reset, 1);
        req_valid = 4'b0000;
        @(negedge clock);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            pulses = 0;
            run_one(vecs[v].id, vecs[v].a, vecs[v].b, lat, y, rid, err);
            chk($sformatf("vec%0d_lat", v), lat, vecs[v].lat);
            chk($sformatf("vec%0d_y", v), y, vecs[v].y);
            chk($sformatf("vec%0d_id", v), rid, vecs[v].id);
            chk($sformatf("vec%0d_err", v), err, 0);
            chk($sformatf("vec%0d_pulses", v), pulses, 1);
        end

        // Contention: all four held valid.
        grants.delete(); rids.delete();
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            req_a[8*i +: 8] = 8'(8'h38 + i);
            req_b[8*i +: 8] = 8'(8'h40 + 8*i);
        end
        req_valid = 4'hF; resp_ready = 1'b1;
        for (int n = 0; n < 200 && grants.size() < 5; n++) @(negedge clock);
        req_valid = 4'h0;
        wait_idle("cont_idle");
        chk("cont_ngrants", grants.size(), 5);
        chk("cont_nresp", rids.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < grants.size()) chk($sformatf("cont_grant%0d", i), grants[i], exp_order[i]);
            if (i < rids.size())   chk($sformatf("cont_rid%0d", i), rids[i], exp_order[i]);
        end

        // Backpressure on the response channel.
        @(negedge clock);
        resp_ready = 1'b0;
        req_a[15:8] = 8'h40; req_b[15:8] = 8'h40; req_valid[1] = 1'b1;
        req_a[23:16] = 8'h38; req_b[23:16] = 8'h38;
        begin
            int n;
            n = 0;
            #1;
            while (!req_ready[1] && n < 20) begin @(negedge clock); #1; n++; end
            @(negedge clock);
            req_valid[1] = 1'b0; req_valid[2] = 1'b1;
            n = 0;
            #1;
            while (!resp_valid && n < 40) begin @(negedge clock); #1; n++; end
            chk("bp_resp_seen", resp_valid, 1);
            for (int c = 0; c < 5; c++) begin
                @(negedge clock); #1;
                chk("bp_valid_hold", resp_valid, 1);
                chk("bp_y_hold", resp_y, 8'h48);
                chk("bp_id_hold", resp_id, 1);
                chk("bp_no_ready", req_ready, 0);
            end
            @(negedge clock);
            resp_ready = 1'b1;
            #1;
            chk("bp_no_grant_in_hs", req_ready, 0);
            @(negedge clock); #1;
            chk("bp_next_grant", req_ready, 4'b0100);
            @(negedge clock);
            req_valid[2] = 1'b0;
            wait_idle("bp_idle");
        end

        // Reset while WAIT is in progress.
        grants.delete(); rids.delete();
        @(negedge clock);
        req_a[31:24] = 8'h40; req_b[31:24] = 8'h48; req_valid[3] = 1'b1;
        req_a[7:0] = 8'h38; req_b[7:0] = 8'h48;
        #1;
        chk("rstw_grant3", req_ready, 4'b1000);
        @(negedge clock);
        req_valid[0] = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock); #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_resp_valid", resp_valid, 0);
        chk("rstw_ready", req_ready, 0);
        chk("rstw_mul_reset", mul_reset, 1);
        reset = 1'b0;
        #1;
        chk("rstw_prio0", req_ready, 4'b0001);
        @(negedge clock);
        req_valid[0] = 1'b0;
        for (int n = 0; n < 100 && grants.size() < 3; n++) @(negedge clock);
        req_valid[3] = 1'b0;
        wait_idle("rstw_idle");
        chk("rstw_ngrants", grants.size(), 3);
        if (grants.size() == 3) begin
            chk("rstw_g1", grants[1], 0);
            chk("rstw_g2", grants[2], 3);
        end
        chk("rstw_nresp", rids.size(), 2);
        if (rids.size() == 2) begin
            chk("rstw_r0", rids[0], 0);
            chk("rstw_r1", rids[1], 3);
        end

        // Randomised traffic against a scoreboard.
        begin
            int acc, issued, done;
            logic [7:0] r;
            acc = -1; issued = 0; done = 0;
            sb.delete();
            for (int cyc = 0; cyc < 5000 && done < NRAND; cyc++) begin
                @(negedge clock);
                if (acc >= 0) begin req_valid[acc] = 1'b0; acc = -1; end
                for (int i = 0; i < 4; i++) begin
                    if (!req_valid[i] && issued < NRAND && $urandom_range(0, 2) == 0) begin
                        r = 8'($urandom);
                        ra[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : r;
                        rb[i] = 8'($urandom);
                        req_a[8*i +: 8] = ra[i];
                        req_b[8*i +: 8] = rb[i];
                        req_valid[i] = 1'b1;
                        issued++;
                    end
                end
                resp_ready = ($urandom_range(0, 3) != 0);
                #1;
                for (int i = 0; i < 4; i++) begin
                    if (req_ready[i]) begin
                        acc = i;
                        sb.push_back('{i, fmul_ref(ra[i], rb[i])});
                    end
                end
                if (resp_valid && resp_ready) begin
                    if (sb.size() == 0) chk("rand_unexpected", 1, 0);
                    else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("rand_y", resp_y, e.y);
                        chk("rand_id", resp_id, e.id);
                        chk("rand_err", resp_err, 0);
                    end
                    done++;
                end
            end
            @(negedge clock);
            if (acc >= 0) req_valid[acc] = 1'b0;
            chk("rand_done", done, NRAND);
            chk("rand_sb_empty", sb.size(), 0);
            wait_idle("rand_idle");
        end

        // Multiplier that never completes.
        stub_en = 1'b0;
`ifdef FMUL_SHARE_CTRL_TIMEOUT_EN
        run_one(0, 8'h38, 8'h40, lat, y, rid, err);
        chk("to_lat", lat, 17);
        chk("to_y", y, 8'h00);
        chk("to_err", err, 1);
        chk("to_id", rid, 0);
`else
        begin
            int seen;
            seen = 0;
            @(negedge clock);
            req_a[7:0] = 8'h38; req_b[7:0] = 8'h40; req_valid[0] = 1'b1;
            resp_ready = 1'b1;
            @(negedge clock);
            req_valid[0] = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clock); #1;
                if (resp_valid) seen++;
            end
            chk("hang_busy", busy, 1);
            chk("hang_no_resp", seen, 0);
            @(negedge clock);
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            #1;
            chk("hang_recover", busy, 0);
        end
`endif
        stub_en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
